// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC sizing helpers, symbol encodings and packer states
package ldpc_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int blk_size(input int gf_log2);
    return (1 << gf_log2) - 1;
  endfunction

  // Soft-read symbol encodings shared with the VN LLR mapping
  localparam logic [1:0] SYM_STRONG0 = 2'b00;
  localparam logic [1:0] SYM_WEAK0   = 2'b01;
  localparam logic [1:0] SYM_STRONG1 = 2'b10;
  localparam logic [1:0] SYM_WEAK1   = 2'b11;

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_PAD   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/ldpc_sym_accum.sv
// rtl/ldpc_sym_accum.sv - symbol accumulator: append above the fill level, pop one column from the bottom
module ldpc_sym_accum
  import ldpc_pkg::*;
#(
  parameter int SYM_WID  = 2,
  parameter int BLK_SIZE = 127,
  parameter int IN_SYMS  = 8,
  localparam int CAP     = BLK_SIZE + IN_SYMS - 1,
  localparam int CNT_W   = clog2(CAP + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_SYMS*SYM_WID-1:0]    in_sym,
  input  logic                          push,
  input  logic                          pop,
  output logic [BLK_SIZE*SYM_WID-1:0]   head,
  output logic [CNT_W-1:0]              cnt
);

  logic [CAP*SYM_WID-1:0] acc_q;
  logic [CAP*SYM_WID-1:0] acc_sh;
  logic [CAP*SYM_WID-1:0] acc_app;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_sh;

  // Storage above cnt_q is always zero, so a pop on a partial column zero-fills it
  always_comb begin
    acc_sh = acc_q;
    cnt_sh = cnt_q;
    if (pop) begin
      acc_sh = acc_q >> (BLK_SIZE * SYM_WID);
      cnt_sh = (cnt_q >= CNT_W'(BLK_SIZE)) ? cnt_q - CNT_W'(BLK_SIZE) : '0;
    end
    acc_app = '0;
    if (push) begin
      acc_app = {{((CAP - IN_SYMS) * SYM_WID){1'b0}}, in_sym} << (int'(cnt_sh) * SYM_WID);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_sh | acc_app;
      cnt_q <= cnt_sh + (push ? CNT_W'(IN_SYMS) : '0);
    end
  end

  assign head = acc_q[BLK_SIZE*SYM_WID-1:0];
  assign cnt  = cnt_q;

endmodule

// File: rtl/ldpc_llr_packer.sv
// rtl/ldpc_llr_packer.sv - packs narrow soft-symbol beats into decoder column words, repairing frame length
module ldpc_llr_packer
  import ldpc_pkg::*;
#(
  parameter int INIT_INFO_WID = 2,
  parameter int GF_SIZE_LOG2  = 7,
  parameter int PCM_COLN      = 72,
  parameter int IN_SYMS       = 8,
  localparam int BLK_SIZE     = blk_size(GF_SIZE_LOG2)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [IN_SYMS*INIT_INFO_WID-1:0]  i_llr_sym,
  input  logic                              i_llr_valid,
  output logic                              o_llr_ready,
  input  logic                              i_llr_last,
  output logic [BLK_SIZE*INIT_INFO_WID-1:0] o_init_info,
  output logic                              o_init_info_valid,
  input  logic                              i_init_info_ready,
  output logic                              o_init_info_last,
  output logic                              o_err_short,
  output logic                              o_err_long
);

  localparam int CAP      = BLK_SIZE + IN_SYMS - 1;
  localparam int FRAME    = PCM_COLN * BLK_SIZE;
  localparam int CNT_W    = clog2(CAP + 1);
  localparam int SYM_W    = clog2(FRAME + 1);
  localparam int COL_W    = (PCM_COLN > 1) ? clog2(PCM_COLN) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PCM_COLN - 1);

  if (IN_SYMS < 1 || IN_SYMS > BLK_SIZE || (FRAME % IN_SYMS) != 0) begin : g_bad_cfg
    $error("ldpc_llr_packer: IN_SYMS must be in 1..BLK_SIZE and divide PCM_COLN*BLK_SIZE");
  end

  logic [1:0]                        state;
  logic [CNT_W-1:0]                  acc_cnt;
  logic [BLK_SIZE*INIT_INFO_WID-1:0] acc_head;
  logic [SYM_W-1:0]                  sym_cnt;
  logic [SYM_W-1:0]                  sym_next;
  logic [COL_W-1:0]                  col_cnt;
  logic                              move_out;
  logic                              accept;
  logic                              frame_full;
  logic                              frame_short;
  logic                              last_load;

  // In PAD the slot is fed every free cycle; the accumulator supplies zeros once empty
  assign move_out    = ((acc_cnt >= CNT_W'(BLK_SIZE)) || (state == ST_PAD)) &&
                       (!o_init_info_valid || i_init_info_ready);
  assign o_llr_ready = (state == ST_FILL) && ((acc_cnt < CNT_W'(BLK_SIZE)) || move_out);
  assign accept      = i_llr_valid && o_llr_ready;
  assign sym_next    = sym_cnt + SYM_W'(IN_SYMS);
  assign frame_full  = accept && (sym_next == SYM_W'(FRAME));
  assign frame_short = accept && i_llr_last && !frame_full;
  assign last_load   = move_out && (col_cnt == COL_LAST);

  ldpc_sym_accum #(
    .SYM_WID  (INIT_INFO_WID),
    .BLK_SIZE (BLK_SIZE),
    .IN_SYMS  (IN_SYMS)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .in_sym (i_llr_sym),
    .push   (accept),
    .pop    (move_out),
    .head   (acc_head),
    .cnt    (acc_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_FILL;
      sym_cnt           <= '0;
      col_cnt           <= '0;
      o_init_info       <= '0;
      o_init_info_valid <= 1'b0;
      o_init_info_last  <= 1'b0;
      o_err_short       <= 1'b0;
      o_err_long        <= 1'b0;
    end else begin
      o_err_short <= frame_short;
      o_err_long  <= frame_full && !i_llr_last;

      if (accept) sym_cnt <= sym_next;

      if (move_out) begin
        o_init_info       <= acc_head;
        o_init_info_valid <= 1'b1;
        o_init_info_last  <= (col_cnt == COL_LAST);
        col_cnt           <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
      end else if (i_init_info_ready) begin
        o_init_info_valid <= 1'b0;
      end

      case (state)
        ST_FILL: begin
          if (frame_short)     state <= ST_PAD;
          else if (frame_full) state <= ST_DRAIN;
        end
        ST_PAD, ST_DRAIN: begin
          // Loading the final column also empties the accumulator
          if (last_load) begin
            state   <= ST_FILL;
            sym_cnt <= '0;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_llr_packer.sv
// tb/tb_ldpc_llr_packer.sv - directed bench for the LLR column packer
module tb_ldpc_llr_packer;

  localparam int W      = 2;
  localparam int BLK    = 127;
  localparam int NS     = 8;
  localparam int COLN   = 72;
  localparam int NBEATS = 1143;
  localparam int FRAME  = COLN * BLK;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*W-1:0]   i_llr_sym;
  logic              i_llr_valid;
  logic              o_llr_ready;
  logic              i_llr_last;
  logic [BLK*W-1:0]  o_init_info;
  logic              o_init_info_valid;
  logic              i_init_info_ready;
  logic              o_init_info_last;
  logic              o_err_short;
  logic              o_err_long;

  always #5 clk = ~clk;

  ldpc_llr_packer #(
    .INIT_INFO_WID (W),
    .GF_SIZE_LOG2  (7),
    .PCM_COLN      (COLN),
    .IN_SYMS       (NS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_llr_sym         (i_llr_sym),
    .i_llr_valid       (i_llr_valid),
    .o_llr_ready       (o_llr_ready),
    .i_llr_last        (i_llr_last),
    .o_init_info       (o_init_info),
    .o_init_info_valid (o_init_info_valid),
    .i_init_info_ready (i_init_info_ready),
    .o_init_info_last  (o_init_info_last),
    .o_err_short       (o_err_short),
    .o_err_long        (o_err_long)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [BLK*W-1:0] col_q[$];
  logic             last_q[$];
  int short_cnt, long_cnt, short_cyc, long_cyc;
  int b15_cyc, blast_cyc, first_valid_cyc, stall_cnt, timeouts, unstable;
  int ready_mode, hold_left, pad_bad;
  logic hold_done, hold_sampled, hold_ready_end, watch_en, watch_pad;
  logic hs_in, pre_valid, pre_ready, pre_last, pre_in_last;
  logic [BLK*W-1:0] pre_word;

  function automatic logic [1:0] symf(input int idx);
    int v;
    v = idx ^ (idx >> 2) ^ (idx >> 5) ^ (idx >> 9);
    return v[1:0];
  endfunction

  function automatic logic [BLK*W-1:0] exp_col(input int base, input int nsyms, input int c);
    logic [BLK*W-1:0] w;
    w = '0;
    for (int j = 0; j < BLK; j++)
      if (c * BLK + j < nsyms) w[j*W +: W] = symf(base + c * BLK + j);
    return w;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    col_q.delete();
    last_q.delete();
    short_cnt = 0; long_cnt = 0; short_cyc = -1; long_cyc = -2;
    b15_cyc = -1; blast_cyc = -1; first_valid_cyc = -1;
    stall_cnt = 0; timeouts = 0; unstable = 0; pad_bad = 0;
    hold_done = 1'b0; hold_sampled = 1'b0; hold_ready_end = 1'b1; hold_left = 0;
    watch_pad = 1'b0;
  endtask

  task automatic tick();
    if (ready_mode == 1) begin
      if (!hold_done && col_q.size() >= 11) begin
        hold_done = 1'b1;
        hold_left = 200;
      end
      if (hold_left > 0) begin
        i_init_info_ready = 1'b0;
        hold_left--;
      end else begin
        i_init_info_ready = 1'($urandom_range(0, 1));
      end
    end else begin
      i_init_info_ready = 1'b1;
    end
    #1;
    if (ready_mode == 1 && hold_done && hold_left == 0 && !hold_sampled) begin
      hold_ready_end = o_llr_ready;
      hold_sampled = 1'b1;
    end
    hs_in       = i_llr_valid && o_llr_ready;
    pre_in_last = i_llr_last;
    pre_valid   = o_init_info_valid;
    pre_ready   = i_init_info_ready;
    pre_word    = o_init_info;
    pre_last    = o_init_info_last;
    @(posedge clk);
    #1;
    cyc++;
    if (pre_valid && pre_ready) begin
      col_q.push_back(pre_word);
      last_q.push_back(pre_last);
    end
    if (pre_valid && !pre_ready &&
        !(o_init_info_valid && o_init_info === pre_word && o_init_info_last === pre_last))
      unstable++;
    if (first_valid_cyc < 0 && o_init_info_valid) first_valid_cyc = cyc;
    if (o_err_short) begin short_cnt++; short_cyc = cyc; end
    if (o_err_long)  begin long_cnt++;  long_cyc  = cyc; end
    if (watch_en && hs_in && pre_in_last) watch_pad = 1'b1;
    if (watch_pad) begin
      if (o_init_info_valid && o_init_info_last) watch_pad = 1'b0;
      else if (o_llr_ready) pad_bad++;
    end
  endtask

  task automatic send_frame(input int base, input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < NS; k++) i_llr_sym[k*W +: W] = symf(base + b * NS + k);
      i_llr_valid = 1'b1;
      i_llr_last  = (b == last_at);
      hs_in = 1'b0;
      for (int t = 0; t < 5000 && !hs_in; t++) begin
        tick();
        if (!hs_in) stall_cnt++;
      end
      if (!hs_in) begin
        timeouts++;
        break;
      end
      if (b == 15) b15_cyc = cyc;
      if (b == nbeats - 1) blast_cyc = cyc;
    end
    i_llr_valid = 1'b0;
    i_llr_last  = 1'b0;
  endtask

  task automatic wait_cols(input int n);
    for (int t = 0; t < 20000 && col_q.size() < n; t++) tick();
    for (int t = 0; t < 4; t++) tick();
  endtask

  task automatic check_frame(input string tag, input int base, input int nsyms, input int first);
    int bad, lasts;
    bad = 0;
    lasts = 0;
    for (int c = 0; c < COLN; c++) begin
      if (first + c >= col_q.size()) bad++;
      else begin
        if (col_q[first+c] !== exp_col(base, nsyms, c)) bad++;
        if (last_q[first+c]) lasts++;
      end
    end
    chk({tag, "_bad_cols"}, bad, 0);
    chk({tag, "_last_count"}, lasts, 1);
    chk({tag, "_last_on_col71"}, (first + COLN - 1 < col_q.size()) ? last_q[first+COLN-1] : 1'b0, 1);
  endtask

  initial begin
    int nz;
    rst = 1'b1;
    i_llr_sym = '0;
    i_llr_valid = 1'b0;
    i_llr_last = 1'b0;
    i_init_info_ready = 1'b1;
    ready_mode = 0;
    watch_en = 1'b0;
    clear_stats();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_word", o_init_info, 0);
    chk("rst_valid", o_init_info_valid, 0);
    chk("rst_last", o_init_info_last, 0);
    chk("rst_err_short", o_err_short, 0);
    chk("rst_err_long", o_err_long, 0);
    chk("rst_llr_ready", o_llr_ready, 1);

    // Full frame, decoder always ready
    clear_stats();
    send_frame(0, NBEATS, NBEATS - 1);
    wait_cols(COLN);
    chk("s1_timeouts", timeouts, 0);
    chk("s1_col_count", col_q.size(), COLN);
    chk("s1_first_col", (col_q.size() > 0) ? (col_q[0] === exp_col(0, FRAME, 0)) : 1'b0, 1);
    chk("s1_latency", first_valid_cyc, b15_cyc + 1);
    chk("s1_input_stalls", stall_cnt, 0);
    check_frame("s1", 0, FRAME, 0);
    chk("s1_err_short", short_cnt, 0);
    chk("s1_err_long", long_cnt, 0);
    chk("s1_ready_after", o_llr_ready, 1);

    // Same frame under random backpressure with a long stall after column 10
    clear_stats();
    ready_mode = 1;
    send_frame(0, NBEATS, NBEATS - 1);
    wait_cols(COLN);
    ready_mode = 0;
    chk("s2_timeouts", timeouts, 0);
    chk("s2_col_count", col_q.size(), COLN);
    check_frame("s2", 0, FRAME, 0);
    chk("s2_unstable", unstable, 0);
    chk("s2_hold_seen", hold_sampled, 1);
    chk("s2_ready_in_hold", hold_ready_end, 0);
    chk("s2_err_pulses", short_cnt + long_cnt, 0);

    // Short frame: last on beat 99
    clear_stats();
    watch_en = 1'b1;
    send_frame(0, 100, 99);
    wait_cols(COLN);
    watch_en = 1'b0;
    chk("s3_col_count", col_q.size(), COLN);
    chk("s3_err_short", short_cnt, 1);
    chk("s3_short_timing", short_cyc, blast_cyc);
    chk("s3_err_long", long_cnt, 0);
    chk("s3_col6", (col_q.size() > 6) ? (col_q[6] === exp_col(0, 800, 6)) : 1'b0, 1);
    nz = 0;
    for (int c = 7; c < COLN; c++) if (c >= col_q.size() || col_q[c] !== '0) nz++;
    chk("s3_zero_cols", nz, 0);
    check_frame("s3", 0, 800, 0);
    chk("s3_ready_during_pad", pad_bad, 0);
    chk("s3_ready_after", o_llr_ready, 1);

    // Long frame followed by a normal frame
    clear_stats();
    send_frame(0, NBEATS, -1);
    nz = blast_cyc;
    send_frame(50000, NBEATS, NBEATS - 1);
    wait_cols(2 * COLN);
    chk("s4_timeouts", timeouts, 0);
    chk("s4_col_count", col_q.size(), 2 * COLN);
    chk("s4_err_long", long_cnt, 1);
    chk("s4_long_timing", long_cyc, nz);
    chk("s4_err_short", short_cnt, 0);
    chk("s4_f2_first_col", (col_q.size() > COLN) ? (col_q[COLN] === exp_col(50000, FRAME, 0)) : 1'b0, 1);
    check_frame("s4_f1", 0, FRAME, 0);
    check_frame("s4_f2", 50000, FRAME, COLN);

    // Reset mid-frame, then a clean frame
    clear_stats();
    send_frame(0, 500, -1);
    for (int k = 0; k < NS; k++) i_llr_sym[k*W +: W] = symf(500 * NS + k);
    i_llr_valid = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_llr_valid = 1'b0;
    #1;
    chk("s5_valid_after_rst", o_init_info_valid, 0);
    chk("s5_ready_after_rst", o_llr_ready, 1);
    clear_stats();
    send_frame(0, NBEATS, NBEATS - 1);
    wait_cols(COLN);
    chk("s5_timeouts", timeouts, 0);
    chk("s5_col_count", col_q.size(), COLN);
    chk("s5_latency", first_valid_cyc, b15_cyc + 1);
    check_frame("s5", 0, FRAME, 0);
    chk("s5_err_pulses", short_cnt + long_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
